mux_scan_nx1: RTL and testbench

MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_next_sel.sv | 36 +++
 rtl/mux_scan_nx1.sv | 99 +++++++++
 tb/tb_mux_scan_nx1.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared mode encodings, scan state enumeration and width helper for mux_scan_nx1.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_DIRECT     = 2'd0,
        ST_SCAN_START = 2'd1,
        ST_SCAN       = 2'd2
    } state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Finds the next enabled channel after cur (wrapping), or the lowest one when start is set.
module rr_next_sel #(
    parameter int unsigned N  = 16,
    parameter int unsigned SW = 4
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] cur,
    input  logic          start,
    output logic [SW-1:0] nxt,
    output logic          found
);

    logic [SW-1:0] low_any;
    logic [SW-1:0] low_after;
    logic          after_f;

    // Descending walk so the last hit is the lowest qualifying index.
    always_comb begin
        low_any   = '0;
        low_after = '0;
        after_f   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) begin
                low_any = SW'(k);
                if (SW'(k) > cur) begin
                    low_after = SW'(k);
                    after_f   = 1'b1;
                end
            end
        end
    end

    assign found = |mask;
    assign nxt   = (start || !after_f) ? low_any : low_after;

endmodule

// File: rtl/mux_scan_nx1.sv
// N:1 registered channel mux with direct select and round-robin auto-scan over enabled channels.
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned W  = 1,
    localparam int unsigned SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  s,
    input  logic           mode,
    input  logic [N-1:0]   en_mask,
    input  logic           hold,
    output logic [W-1:0]   out,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid
);

    state_e        state_q;
    logic [SW-1:0] ptr_q;
    logic [W-1:0]  out_q;
    logic [SW-1:0] out_ch_q;
    logic          out_valid_q;

    logic [SW-1:0] nxt;
    logic          found;
    logic          dir_ok;
    logic [W-1:0]  dir_data;
    logic [W-1:0]  scan_data;

    rr_next_sel #(
        .N  (N),
        .SW (SW)
    ) u_next (
        .mask  (en_mask),
        .cur   (ptr_q),
        .start (state_q == ST_SCAN_START),
        .nxt   (nxt),
        .found (found)
    );

    // Loop-based lookup keeps an out-of-range s from indexing past the bus.
    always_comb begin
        dir_ok    = 1'b0;
        dir_data  = '0;
        scan_data = '0;
        for (int k = 0; k < N; k++) begin
            if (SW'(k) == s) begin
                dir_ok   = en_mask[k];
                dir_data = i[k*W +: W];
            end
            if (SW'(k) == nxt) begin
                scan_data = i[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DIRECT;
            ptr_q       <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (!hold) begin
            unique case (state_q)
                ST_DIRECT: begin
                    out_q       <= dir_ok ? dir_data : '0;
                    out_ch_q    <= s;
                    out_valid_q <= dir_ok;
                    if (mode == MODE_SCAN) begin
                        state_q <= ST_SCAN_START;
                    end
                end
                ST_SCAN_START, ST_SCAN: begin
                    // Empty mask parks the pointer so scanning resumes where it left off.
                    if (found) begin
                        ptr_q       <= nxt;
                        out_q       <= scan_data;
                        out_ch_q    <= nxt;
                        out_valid_q <= 1'b1;
                    end else begin
                        out_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                    state_q <= (mode == MODE_DIRECT) ? ST_DIRECT : ST_SCAN;
                end
                default: state_q <= ST_DIRECT;
            endcase
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Randomized and directed bench for mux_scan_nx1 against a behavioural scan model.
module tb_mux_scan_nx1;

    localparam int unsigned N  = 16;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 4;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] i_v;
    logic [SW-1:0]  s_v;
    logic           mode_v;
    logic [N-1:0]   en_v;
    logic           hold_v;
    logic [W-1:0]   out_w;
    logic [SW-1:0]  ch_w;
    logic           valid_w;

    int n_tests;
    int n_fail;

    // model: 0 = direct, 1 = scan start, 2 = scanning
    int           m_st;
    int           m_ptr;
    int           m_ch;
    logic [W-1:0] m_out;
    logic         m_valid;

    mux_scan_nx1 #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i_v),
        .s         (s_v),
        .mode      (mode_v),
        .en_mask   (en_v),
        .hold      (hold_v),
        .out       (out_w),
        .out_ch    (ch_w),
        .out_valid (valid_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [W-1:0] chan(input logic [N*W-1:0] v, input int k);
        return W'(v >> (k * W));
    endfunction

    function automatic int next_en(input logic [N-1:0] m, input int cur, input bit from_start);
        int c;
        for (int off = 0; off < N; off++) begin
            c = from_start ? off : (cur + 1 + off) % N;
            if (m[4'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ptr = 0; m_ch = 0; m_out = '0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        int  k;
        bit  ok;
        if (hold_v) return;
        if (m_st == 0) begin
            ok      = (int'(s_v) < N) && en_v[s_v];
            m_out   = ok ? chan(i_v, int'(s_v)) : '0;
            m_ch    = int'(s_v);
            m_valid = ok;
            m_st    = mode_v ? 1 : 0;
        end else begin
            k = next_en(en_v, m_ptr, m_st == 1);
            if (k >= 0) begin
                m_ptr   = k;
                m_ch    = k;
                m_out   = chan(i_v, k);
                m_valid = 1'b1;
            end else begin
                m_out   = '0;
                m_valid = 1'b0;
            end
            m_st = mode_v ? 2 : 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_out"}, 32'(out_w), 32'(m_out));
        check({tag, "_ch"}, 32'(ch_w), 32'(m_ch));
        check({tag, "_valid"}, 32'(valid_w), 32'(m_valid));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) i_v[k*W +: W] = W'($urandom);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_model("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_ch(input int target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            rand_data();
            tick(tag);
            if (m_ch == target && m_valid) hit = 1'b1;
        end
        if (!hit) check({tag, "_reach"}, 32'(0), 32'(1));
    endtask

    int seq8421 [4] = '{0, 5, 10, 15};
    int seq06 [2] = '{1, 2};
    int r;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; i_v = '0; s_v = '0; mode_v = 1'b0; en_v = '0; hold_v = 1'b0;
        model_reset();
        #2;
        compare_model("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // walking one through direct select
        mode_v = 1'b0; en_v = 16'hFFFF;
        for (int k = 0; k < N; k++) begin
            i_v = (N*W)'(1) << (k * W);
            s_v = 4'(k);
            tick("walk");
            check("walk_one", 32'(out_w), 32'd1);
        end

        // disabled channel in direct mode
        en_v = 16'hFFFE; s_v = '0; i_v = (N*W)'(1);
        tick("dir_masked");
        check("dir_masked_v", 32'(valid_w), 32'd0);

        // scan over sparse mask
        en_v = 16'h8421; mode_v = 1'b1;
        rand_data();
        tick("scan_enter");
        for (int j = 0; j < 12; j++) begin
            rand_data();
            tick("scan8421");
            check("seq8421", 32'(ch_w), 32'(seq8421[j % 4]));
            check("seq8421_data", 32'(out_w), 32'(chan(i_v, seq8421[j % 4])));
        end

        // mask drops to zero at channel 7, then restored to channel 8 only
        en_v = 16'hFFFF;
        run_to_ch(7, "to7");
        en_v = 16'h0000;
        tick("mask0");
        check("mask0_valid", 32'(valid_w), 32'd0);
        check("mask0_ch", 32'(ch_w), 32'd7);
        en_v = 16'h0100;
        tick("mask_restore");
        check("restore_ch", 32'(ch_w), 32'd8);
        check("restore_valid", 32'(valid_w), 32'd1);

        // hold freezes everything, even with mode and mask changes
        en_v = 16'hFFFF;
        run_to_ch(3, "to3");
        hold_v = 1'b1; mode_v = 1'b0; en_v = 16'h0000;
        for (int j = 0; j < 3; j++) begin
            rand_data();
            tick("hold");
            check("hold_ch", 32'(ch_w), 32'd3);
        end
        hold_v = 1'b0; mode_v = 1'b1; en_v = 16'hFFFF;
        tick("hold_release");
        check("release_ch", 32'(ch_w), 32'd4);

        // reset mid-scan then restart scanning
        run_to_ch(9, "to9");
        async_reset();
        check("rst_out_zero", 32'(out_w), 32'd0);
        en_v = 16'h0006; mode_v = 1'b1;
        tick("rst_direct");
        for (int j = 0; j < 4; j++) begin
            rand_data();
            tick("post_rst_scan");
            check("seq06", 32'(ch_w), 32'(seq06[j % 2]));
        end

        // random soak
        for (int c = 0; c < 500; c++) begin
            rand_data();
            s_v = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 7));
                if (r == 0)      en_v = '0;
                else if (r == 1) en_v = N'(1) << $urandom_range(0, N - 1);
                else             en_v = N'($urandom);
            end
            if ($urandom_range(0, 9) == 0) mode_v = ~mode_v;
            hold_v = ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
